// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle control unit for a MIPS-lite core.
// Latches the fetched word into IR, decodes it and steps the datapath through
// FETCH/DECODE/EXE/MEM/WB, driving IFU, GRF, ALU and DM controls.
//
// Build option: define MC_CTRL_INSTR_CNT_EN to add a 32-bit retired-instruction
// counter on instr_cnt; without it instr_cnt is tied to 0.
//
// Handshake note: there is no valid/ready handshake. The IFU is assumed to
// present a stable instr whenever the FSM is in S_FETCH, and br_cmp is
// assumed valid during S_EXE of a beq.
module mc_ctrl #(
    parameter bit HALT_ON_ILLEGAL = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr,
    input  logic        br_cmp,
    output logic [31:0] ir,
    output logic        pc_en,
    output logic [1:0]  nPC_sel,
    output logic        reg_we,
    output logic [1:0]  reg_dst,
    output logic [1:0]  wd_sel,
    output logic        alu_src,
    output logic [2:0]  alu_op,
    output logic [1:0]  ext_op,
    output logic        mem_we,
    output logic        illegal,
    output logic [2:0]  state,
    output logic [31:0] instr_cnt
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXE    = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_e;

    typedef enum logic [3:0] {
        OP_NOP, OP_ADDU, OP_SUBU, OP_ORI, OP_LUI, OP_LW, OP_SW,
        OP_BEQ, OP_J, OP_JAL, OP_JR, OP_ILL
    } op_e;

    state_e      state_q, state_d;
    logic [31:0] ir_q, ir_d;
    op_e         op;

    logic [1:0]  npc_dec;
    logic [1:0]  reg_dst_dec;
    logic [1:0]  wd_sel_dec;
    logic        alu_src_dec;
    logic [2:0]  alu_op_dec;
    logic [1:0]  ext_op_dec;

    logic        pc_en_c, reg_we_c, mem_we_c, illegal_c;
    logic [1:0]  npc_c;

    // Classify the instruction held in IR.
    always_comb begin
        op = OP_ILL;
        case (ir_q[31:26])
            6'b000000: begin
                case (ir_q[5:0])
                    6'b100001: op = OP_ADDU;
                    6'b100011: op = OP_SUBU;
                    6'b001000: op = OP_JR;
                    6'b000000: op = OP_NOP;   // sll of any form is a nop here
                    default:   op = OP_ILL;
                endcase
            end
            6'b001101: op = OP_ORI;
            6'b001111: op = OP_LUI;
            6'b100011: op = OP_LW;
            6'b101011: op = OP_SW;
            6'b000100: op = OP_BEQ;
            6'b000010: op = OP_J;
            6'b000011: op = OP_JAL;
            default:   op = OP_ILL;
        endcase
    end

    // Datapath controls decoded from IR; they hold in every state.
    always_comb begin
        npc_dec     = 2'b00;
        reg_dst_dec = 2'b00;
        wd_sel_dec  = 2'b00;
        alu_src_dec = 1'b0;
        alu_op_dec  = 3'b000;
        ext_op_dec  = 2'b00;
        case (op)
            OP_ADDU: reg_dst_dec = 2'b01;
            OP_SUBU: begin
                reg_dst_dec = 2'b01;
                alu_op_dec  = 3'b001;
            end
            OP_ORI: begin
                alu_op_dec  = 3'b010;
                alu_src_dec = 1'b1;
            end
            OP_LUI: begin
                alu_op_dec  = 3'b011;
                alu_src_dec = 1'b1;
                ext_op_dec  = 2'b10;
            end
            OP_LW: begin
                alu_src_dec = 1'b1;
                ext_op_dec  = 2'b01;
                wd_sel_dec  = 2'b01;
            end
            OP_SW: begin
                alu_src_dec = 1'b1;
                ext_op_dec  = 2'b01;
            end
            OP_BEQ: begin
                alu_op_dec = 3'b001;
                ext_op_dec = 2'b01;
                npc_dec    = 2'b01;
            end
            OP_J:  npc_dec = 2'b10;
            OP_JAL: begin
                npc_dec     = 2'b10;
                reg_dst_dec = 2'b10;
                wd_sel_dec  = 2'b10;
            end
            OP_JR:   npc_dec = 2'b11;
            default: ;
        endcase
    end

    // Next-state, IR load and per-state enables.
    always_comb begin
        state_d   = state_q;
        ir_d      = ir_q;
        pc_en_c   = 1'b0;
        reg_we_c  = 1'b0;
        mem_we_c  = 1'b0;
        illegal_c = 1'b0;
        npc_c     = npc_dec;
        case (state_q)
            S_FETCH: begin
                ir_d    = instr;
                pc_en_c = 1'b1;
                npc_c   = 2'b00;
                state_d = S_DECODE;
            end
            S_DECODE: begin
                case (op)
                    OP_ADDU, OP_SUBU, OP_ORI, OP_LUI,
                    OP_LW, OP_SW, OP_BEQ: state_d = S_EXE;
                    OP_J, OP_JR: begin
                        pc_en_c = 1'b1;
                        state_d = S_FETCH;
                    end
                    OP_JAL: state_d = S_WB;
                    OP_NOP: state_d = S_FETCH;
                    default: begin
                        illegal_c = 1'b1;
                        state_d   = HALT_ON_ILLEGAL ? S_HALT : S_FETCH;
                    end
                endcase
            end
            S_EXE: begin
                if (op == OP_BEQ) begin
                    // Not-taken leaves the PC at the +4 value written in FETCH.
                    pc_en_c = br_cmp;
                    state_d = S_FETCH;
                end else if (op == OP_LW || op == OP_SW) begin
                    state_d = S_MEM;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                if (op == OP_SW) begin
                    mem_we_c = 1'b1;
                    state_d  = S_FETCH;
                end else begin
                    state_d = S_WB;
                end
            end
            S_WB: begin
                reg_we_c = 1'b1;
                // jal writes $31 with PC+4 while redirecting the PC.
                if (op == OP_JAL) pc_en_c = 1'b1;
                state_d = S_FETCH;
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_FETCH;
        endcase
    end

    // State and IR registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
            ir_q    <= 32'd0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
        end
    end

`ifdef MC_CTRL_INSTR_CNT_EN
    logic [31:0] cnt_q, cnt_d;
    logic        retire;

    // One count per return to FETCH from a working state; wraps naturally.
    always_comb begin
        retire = (state_d == S_FETCH) &&
                 (state_q == S_DECODE || state_q == S_EXE ||
                  state_q == S_MEM    || state_q == S_WB);
        cnt_d  = retire ? cnt_q + 32'd1 : cnt_q;
    end

    // Retired-instruction counter register.
    always_ff @(posedge clk) begin
        if (reset) cnt_q <= 32'd0;
        else       cnt_q <= cnt_d;
    end

    assign instr_cnt = cnt_q;
`else
    assign instr_cnt = 32'd0;
`endif

    // Enables are suppressed while reset is asserted so an aborted
    // instruction cannot write anything.
    assign pc_en   = pc_en_c  & ~reset;
    assign reg_we  = reg_we_c & ~reset;
    assign mem_we  = mem_we_c & ~reset;
    assign nPC_sel = npc_c;
    assign illegal = illegal_c;
    assign reg_dst = reg_dst_dec;
    assign wd_sel  = wd_sel_dec;
    assign alu_src = alu_src_dec;
    assign alu_op  = alu_op_dec;
    assign ext_op  = ext_op_dec;
    assign ir      = ir_q;
    assign state   = state_q;

endmodule
